// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - FE package: RAS checkpoint macros, RAS op encoding, proc params
//
// Purpose : shared front-end definitions for the return address stack.
//   `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ptr_width_mp, cnt_width_mp)
//       declares bp_fe_ras_ckpt_s with fields {top (optional), ptr, cnt}.
//   `BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, ptr_width_mp, cnt_width_mp)
//       packed width of that struct, for use in bp_fe_branch_metadata_fwd_s.
// Optional feature macro: BP_FE_RAS_TOP_REPAIR_EN (adds the top-entry value
// to the checkpoint so a redirect can repair a clobbered top entry).

`ifndef BP_FE_PKG_MACROS_SVH
`define BP_FE_PKG_MACROS_SVH

`ifdef BP_FE_RAS_TOP_REPAIR_EN
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ptr_width_mp, cnt_width_mp) \
    typedef struct packed { \
        logic [vaddr_width_mp-1:0] top; \
        logic [ptr_width_mp-1:0]   ptr; \
        logic [cnt_width_mp-1:0]   cnt; \
    } bp_fe_ras_ckpt_s

`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, ptr_width_mp, cnt_width_mp) \
    ((vaddr_width_mp) + (ptr_width_mp) + (cnt_width_mp))
`else
`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, ptr_width_mp, cnt_width_mp) \
    typedef struct packed { \
        logic [ptr_width_mp-1:0]   ptr; \
        logic [cnt_width_mp-1:0]   cnt; \
    } bp_fe_ras_ckpt_s

`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, ptr_width_mp, cnt_width_mp) \
    ((ptr_width_mp) + (cnt_width_mp))
`endif

`endif

package bp_fe_pkg;

    // Processor parameter set as seen by the front end.
    typedef struct packed {
        int vaddr_width;
        int ras_els;
    } bp_fe_proc_param_s;

    localparam bp_fe_proc_param_s bp_fe_default_cfg_p = '{vaddr_width: 39, ras_els: 8};

    typedef enum logic [2:0] {
        e_ras_idle,
        e_ras_push,
        e_ras_pop,
        e_ras_swap,
        e_ras_restore
    } bp_fe_ras_op_e;

    // Resolves the per-cycle request set to a single stack operation.
    // A simultaneous push+pop on an empty stack has nothing to swap with,
    // so it degrades to a plain push; a pop on an empty stack is dropped.
    function automatic bp_fe_ras_op_e bp_fe_ras_decode(
        input logic restore_v,
        input logic push_v,
        input logic pop_v,
        input logic empty
    );
        if (restore_v)                         return e_ras_restore;
        else if (push_v && pop_v && !empty)    return e_ras_swap;
        else if (push_v)                       return e_ras_push;
        else if (pop_v && !empty)              return e_ras_pop;
        else                                   return e_ras_idle;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - entry array: one async read port, one sync write port
//
// Ports:
//   clk_i     clock, write on posedge
//   w_v_i     write enable
//   w_addr_i  write index
//   w_data_i  write data
//   r_addr_i  read index (combinational read)
//   r_data_o  read data
// Contents are not reset.

module bsg_mem_1r1w
    import bp_fe_pkg::*;
#(
    parameter  int width_p      = 39,
    parameter  int els_p        = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_ras.sv
// rtl/bp_fe_ras.sv - circular return address stack with checkpoint repair
//
// Purpose : multi-entry RAS for the FE PC generator (IF2). Pushed on fetched
//   calls, popped on fetched returns, restored from a branch-metadata
//   checkpoint on backend redirect. Top entry feeds next-PC selection.
// Ports:
//   clk_i           clock
//   reset_n_i       asynchronous active-low reset (clears ptr/cnt only)
//   push_v_i        push request, push_addr_i = return address
//   pop_v_i         pop request
//   tgt_o/tgt_v_o   top-of-stack target (0 when empty) / non-empty
//   ckpt_o          current checkpoint {[top,] ptr, cnt}
//   restore_v_i     restore from restore_ckpt_i (overrides push/pop)
//   full_o          occupancy == ras_els_p
// Optional feature macro: BP_FE_RAS_TOP_REPAIR_EN.

module bp_fe_ras
    import bp_fe_pkg::*;
#(
    parameter  int vaddr_width_p     = bp_fe_default_cfg_p.vaddr_width,
    parameter  int ras_els_p         = bp_fe_default_cfg_p.ras_els,
    localparam int ras_ptr_width_lp  = $clog2(ras_els_p),
    localparam int ras_cnt_width_lp  = $clog2(ras_els_p + 1),
    localparam int ras_ckpt_width_lp = `BP_FE_RAS_CKPT_WIDTH(vaddr_width_p, ras_ptr_width_lp, ras_cnt_width_lp)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         push_v_i,
    input  logic [vaddr_width_p-1:0]     push_addr_i,
    input  logic                         pop_v_i,
    output logic [vaddr_width_p-1:0]     tgt_o,
    output logic                         tgt_v_o,
    output logic [ras_ckpt_width_lp-1:0] ckpt_o,
    input  logic                         restore_v_i,
    input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i,
    output logic                         full_o
);

    `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_p, ras_ptr_width_lp, ras_cnt_width_lp);

    localparam logic [ras_cnt_width_lp-1:0] cnt_max_lp = ras_cnt_width_lp'(ras_els_p);

    logic [ras_ptr_width_lp-1:0] ptr_r, ptr_n, ptr_inc;
    logic [ras_cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                        empty, full;
    logic                        w_v;
    logic [ras_ptr_width_lp-1:0] w_addr;
    logic [vaddr_width_p-1:0]    w_data;
    logic [vaddr_width_p-1:0]    top_data;
    bp_fe_ras_op_e               op;
    bp_fe_ras_ckpt_s             ckpt_li, ckpt_lo;

    assign empty   = (cnt_r == '0);
    assign full    = (cnt_r == cnt_max_lp);
    // Truncation to the pointer width gives the modulo-ras_els_p wrap.
    assign ptr_inc = ptr_r + 1'b1;
    assign ckpt_li = restore_ckpt_i;
    assign op      = bp_fe_ras_decode(restore_v_i, push_v_i, pop_v_i, empty);

    always_comb begin
        ptr_n  = ptr_r;
        cnt_n  = cnt_r;
        w_v    = 1'b0;
        w_addr = ptr_inc;
        w_data = push_addr_i;
        case (op)
            e_ras_restore: begin
                ptr_n = ckpt_li.ptr;
                cnt_n = ckpt_li.cnt;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
                // Rewrite the saved top so a wrong-path pop+push that
                // clobbered it is undone together with the pointer.
                w_v    = 1'b1;
                w_addr = ckpt_li.ptr;
                w_data = ckpt_li.top;
`endif
            end
            e_ras_push: begin
                // At full the oldest entry is overwritten and cnt saturates.
                ptr_n  = ptr_inc;
                cnt_n  = full ? cnt_r : cnt_r + 1'b1;
                w_v    = 1'b1;
                w_addr = ptr_inc;
            end
            e_ras_swap: begin
                w_v    = 1'b1;
                w_addr = ptr_r;
            end
            e_ras_pop: begin
                ptr_n = ptr_r - 1'b1;
                cnt_n = cnt_r - 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
            cnt_r <= '0;
        end else begin
            ptr_r <= ptr_n;
            cnt_r <= cnt_n;
        end
    end

    bsg_mem_1r1w #(
        .width_p (vaddr_width_p),
        .els_p   (ras_els_p)
    ) entries (
        .clk_i    (clk_i),
        .w_v_i    (w_v),
        .w_addr_i (w_addr),
        .w_data_i (w_data),
        .r_addr_i (ptr_r),
        .r_data_o (top_data)
    );

    // Gating on cnt keeps uninitialised entries off the outputs.
    assign tgt_o   = empty ? '0 : top_data;
    assign tgt_v_o = !empty;
    assign full_o  = full;

    assign ckpt_lo.ptr = ptr_r;
    assign ckpt_lo.cnt = cnt_r;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
    assign ckpt_lo.top = tgt_o;
`endif
    assign ckpt_o = ckpt_lo;

endmodule

// File: tb/tb_bp_fe_ras.sv
// tb/tb_bp_fe_ras.sv - self-checking bench for bp_fe_ras

module tb_bp_fe_ras;

    localparam int VW  = 39;
    localparam int ELS = 8;
    localparam int PW  = 3;
    localparam int CW  = 4;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
    localparam int KW  = VW + PW + CW;
`else
    localparam int KW  = PW + CW;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          push_v_i;
    logic [VW-1:0] push_addr_i;
    logic          pop_v_i;
    logic [VW-1:0] tgt_o;
    logic          tgt_v_o;
    logic [KW-1:0] ckpt_o;
    logic          restore_v_i;
    logic [KW-1:0] restore_ckpt_i;
    logic          full_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_ras #(
        .vaddr_width_p (VW),
        .ras_els_p     (ELS)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .push_v_i       (push_v_i),
        .push_addr_i    (push_addr_i),
        .pop_v_i        (pop_v_i),
        .tgt_o          (tgt_o),
        .tgt_v_o        (tgt_v_o),
        .ckpt_o         (ckpt_o),
        .restore_v_i    (restore_v_i),
        .restore_ckpt_i (restore_ckpt_i),
        .full_o         (full_o)
    );

    typedef struct {
        logic          push;
        logic [VW-1:0] addr;
        logic          pop;
        logic [VW-1:0] tgt;
        logic          v;
        int            cnt;
        logic          full;
    } vec_t;

    typedef struct {
        logic [VW-1:0] tgt;
        logic          v;
        int            cnt;
        logic          full;
        int            ptr;   // -1: not checked
        string         name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.name, " tgt"},  64'(tgt_o), 64'(e.tgt));
        chk({e.name, " v"},    64'(tgt_v_o), 64'(e.v));
        chk({e.name, " cnt"},  64'(ckpt_o[CW-1:0]), 64'(e.cnt));
        chk({e.name, " full"}, 64'(full_o), 64'(e.full));
        if (e.ptr >= 0)
            chk({e.name, " ptr"}, 64'(ckpt_o[PW+CW-1:CW]), 64'(e.ptr));
    endtask

    function automatic exp_t mk(input logic [VW-1:0] tgt, input logic v, input int cnt,
                                input logic full, input int ptr, input string name);
        exp_t e;
        e.tgt = tgt; e.v = v; e.cnt = cnt; e.full = full; e.ptr = ptr; e.name = name;
        return e;
    endfunction

    task automatic step(input logic push, input logic [VW-1:0] addr, input logic pop,
                        input logic rst_v, input logic [KW-1:0] ck, input exp_t e);
        exp_t got;
        @(negedge clk_i);
        push_v_i       = push;
        push_addr_i    = addr;
        pop_v_i        = pop;
        restore_v_i    = rst_v;
        restore_ckpt_i = ck;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            got = sb.pop_front();
            check_outputs(got);
        end
        push_v_i    = 1'b0;
        pop_v_i     = 1'b0;
        restore_v_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW-1:0] ck;
        logic [VW-1:0] a;

        reset_n_i      = 1'b0;
        push_v_i       = 1'b0;
        push_addr_i    = '0;
        pop_v_i        = 1'b0;
        restore_v_i    = 1'b0;
        restore_ckpt_i = '0;

        // Basic push/pop.
        vecs.push_back('{1'b1, 39'h1000, 1'b0, 39'h1000, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b1, 39'h2000, 1'b0, 39'h2000, 1'b1, 2, 1'b0});
        vecs.push_back('{1'b1, 39'h3000, 1'b0, 39'h3000, 1'b1, 3, 1'b0});
        vecs.push_back('{1'b0, 39'h0,    1'b1, 39'h2000, 1'b1, 2, 1'b0});
        vecs.push_back('{1'b0, 39'h0,    1'b1, 39'h1000, 1'b1, 1, 1'b0});
        vecs.push_back('{1'b0, 39'h0,    1'b1, 39'h0,    1'b0, 0, 1'b0});
        // Nine pushes: last one wraps over the oldest, cnt saturates at 8.
        for (int i = 1; i <= 9; i++) begin
            a = VW'(i * 'h100);
            vecs.push_back('{1'b1, a, 1'b0, a, 1'b1, (i > 8) ? 8 : i, (i >= 8)});
        end
        // Pops: 0x800 down to 0x200 remain as tops, then empty, then underflow.
        for (int i = 7; i >= 1; i--) begin
            a = VW'((i + 1) * 'h100);
            vecs.push_back('{1'b0, 39'h0, 1'b1, a, 1'b1, i, 1'b0});
        end
        vecs.push_back('{1'b0, 39'h0, 1'b1, 39'h0, 1'b0, 0, 1'b0});
        vecs.push_back('{1'b0, 39'h0, 1'b1, 39'h0, 1'b0, 0, 1'b0});

        #3;
        check_outputs(mk('0, 1'b0, 0, 1'b0, 0, "in_reset"));
        chk("in_reset ckpt", 64'(ckpt_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].push, vecs[i].addr, vecs[i].pop, 1'b0, '0,
                 mk(vecs[i].tgt, vecs[i].v, vecs[i].cnt, vecs[i].full, -1,
                    $sformatf("vec%0d", i)));

        // Underflow from a fresh reset leaves ptr/cnt at zero.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1, 1'b0, '0, mk('0, 1'b0, 0, 1'b0, 0, "underflow"));
        step(1'b1, 39'hABC, 1'b0, 1'b0, '0, mk(39'hABC, 1'b1, 1, 1'b0, 1, "push_after_uf"));

        // Push+pop in one cycle replaces the top in place.
        step(1'b1, 39'h2000, 1'b0, 1'b0, '0, mk(39'h2000, 1'b1, 2, 1'b0, 2, "push2000"));
        step(1'b1, 39'h5000, 1'b1, 1'b0, '0, mk(39'h5000, 1'b1, 2, 1'b0, 2, "swap"));
        step(1'b0, '0, 1'b1, 1'b0, '0, mk(39'hABC, 1'b1, 1, 1'b0, 1, "pop_after_swap"));

        // Checkpoint, wrong-path pop+push, then restore with a competing push.
        step(1'b1, 39'h2000, 1'b0, 1'b0, '0, mk(39'h2000, 1'b1, 2, 1'b0, 2, "ck_setup"));
`ifdef BP_FE_RAS_TOP_REPAIR_EN
        ck = {39'h2000, 3'd2, 4'd2};
`else
        ck = {3'd2, 4'd2};
`endif
        chk("ckpt_value", 64'(ckpt_o), 64'(ck));
        step(1'b0, '0, 1'b1, 1'b0, '0, mk(39'hABC, 1'b1, 1, 1'b0, 1, "wp_pop"));
        step(1'b1, 39'h7777, 1'b0, 1'b0, '0, mk(39'h7777, 1'b1, 2, 1'b0, 2, "wp_push"));
`ifdef BP_FE_RAS_TOP_REPAIR_EN
        step(1'b1, 39'h9999, 1'b0, 1'b1, ck, mk(39'h2000, 1'b1, 2, 1'b0, 2, "restore"));
`else
        step(1'b1, 39'h9999, 1'b0, 1'b1, ck, mk(39'h7777, 1'b1, 2, 1'b0, 2, "restore"));
`endif

        // Build cnt=5, then reset asynchronously mid-cycle.
        step(1'b1, 39'h11, 1'b0, 1'b0, '0, mk(39'h11, 1'b1, 3, 1'b0, 3, "fill3"));
        step(1'b1, 39'h22, 1'b0, 1'b0, '0, mk(39'h22, 1'b1, 4, 1'b0, 4, "fill4"));
        step(1'b1, 39'h33, 1'b0, 1'b0, '0, mk(39'h33, 1'b1, 5, 1'b0, 5, "fill5"));
        #2;
        reset_n_i = 1'b0;
        #1;
        check_outputs(mk('0, 1'b0, 0, 1'b0, 0, "async_rst"));
        chk("async_rst ckpt", 64'(ckpt_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b1, 39'h40, 1'b0, 1'b0, '0, mk(39'h40, 1'b1, 1, 1'b0, 1, "push_after_rst"));

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
